count_seq_monitor: RTL and testbench
====================================

Name: count_seq_monitor

Overview:
- Downstream consumer of the 3-bit cycle counters: the binary mod-7 counter (mode A, 0..6) and the skip-sequence counter (mode B, 0-1-2-4-6).
- Samples the counter output, checks each step against the legal next value for the selected mode and declares lock after a run of correct steps.
- Reports wraps, sequence errors and a saturating error count to status/debug logic.

Parameters:
- ERR_CNT_W, 8, width of saturating error counter
- LOCK_THRESH, 3, consecutive correct transitions required to enter LOCKED (legal range 1..15)

Ports:
- clk  input  1  rising-edge clock, shared with the monitored counter
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = mode A (0..6 binary), 1 = mode B (0,1,2,4,6)
- valid_in  input  1  count_in is sampled this cycle
- count_in  input  3  counter value under test
- clear  input  1  synchronous clear of err_count and err_sticky
- locked  output  1  high while in LOCKED
- wrap_pulse  output  1  one-cycle pulse on a locked 6->0 step
- err_pulse  output  1  one-cycle pulse on any detected error
- err_sticky  output  1  set on first error, held until clear or rst
- err_count  output  ERR_CNT_W  number of errors, saturating at all-ones

Behaviour:
- All outputs are registered. Response appears on the clk edge after the sampled cycle, so latency is 1.
- Reset (async assert, any time): state=IDLE; prev=0; good_cnt=0; mode_q=mode reset value 0; all outputs 0.
- valid_in=0: state, prev, good_cnt and counters hold; pulses are 0.
- Legal values:
  - Mode A: 0..6; 7 is illegal.
  - Mode B: 0,1,2,4,6; 3, 5 and 7 are illegal.
- Expected next value nxt(prev):
  - Mode A: prev+1, with 6->0.
  - Mode B: 0->1, 1->2, 2->4, 4->6, 6->0.
- Illegal value in any state: err_pulse=1, err_count+1, err_sticky=1; next state IDLE; good_cnt=0.
- IDLE, legal sample: prev=count_in, good_cnt=0, go to ACQUIRE. No error is flagged in IDLE.
- ACQUIRE, legal sample:
  - count_in==nxt(prev): good_cnt+1. When the new good_cnt reaches LOCK_THRESH, go to LOCKED and reset good_cnt to 0.
  - Mismatch: good_cnt=0, stay in ACQUIRE, no error.
  - In both cases prev=count_in.
- LOCKED, legal sample:
  - Match: stay in LOCKED. wrap_pulse=1 when prev==6 and count_in==0.
  - Mismatch: err_pulse=1, err_count+1, err_sticky=1, go to ACQUIRE.
  - In both cases prev=count_in.
- A repeated value (count_in==prev) counts as a mismatch unless the optional feature below is compiled in.
- Mode change: mode is registered into mode_q every cycle. If mode!=mode_q, force IDLE and good_cnt=0 on that edge. This overrides the valid sample, and no error or wrap is reported.
- err_count saturates at 2^ERR_CNT_W-1. Further errors still pulse err_pulse.
- clear=1: err_count=0 and err_sticky=0 on that edge. This takes priority over a simultaneous error, whose err_pulse is still asserted. State and lock are unaffected.
- A monitored counter reset mid-run (e.g. 3->0) is a mismatch: in LOCKED it is flagged as an error; in ACQUIRE it only restarts acquisition.

Optional Feature:
- Macro: COUNT_SEQ_HOLD_OK_EN.
- Defined: a legal count_in==prev is treated as a hold. No error, no good_cnt change, no wrap, state unchanged. This supports counters with an enable.
- Undefined: a hold is a mismatch, handled per Behaviour.

Decomposition:
- Package count_seq_pkg contains:
  - State enum {IDLE, ACQUIRE, LOCKED}
  - Constants MODE_A=1'b0, MODE_B=1'b1, LAST_VAL=3'd6
  - Functions is_legal(mode,val) and next_val(mode,val)
- One sub-module, count_seq_next: combinational; inputs mode, prev, count_in; outputs legal, match, is_wrap. It is instantiated once in count_seq_monitor.

Test Plan (LOCK_THRESH=3):
- Mode A, rst for 2 cycles then valid every cycle with 0,1,2,3,4,5,6,0 -> locked rises on the edge after sample 3, wrap_pulse high exactly once (after the 6->0 sample), err_count=0.
- Mode B, samples 0,1,2,4,6,0,1 -> lock after sample 4, one wrap_pulse after the 6->0 step; then inject 5 -> err_pulse, err_count=1, state IDLE, locked=0.
- Mode A locked at 3, next sample 0 (counter reset) -> err_pulse, err_count=1, locked=0; continuing 1,2,3 -> relock, err_sticky still 1.
- 260 consecutive illegal 7s with ERR_CNT_W=8 -> err_count stops at 255; then clear=1 for 1 cycle together with one more 7 -> err_count=0, err_sticky=0, err_pulse=1.
- Locked in mode A, toggle mode to 1 -> next edge: locked=0, state IDLE, no err_pulse; mode B sequence then relocks.
- Locked, sample 4,4:
  - Without the macro: err_pulse on the second 4.
  - With COUNT_SEQ_HOLD_OK_EN: no error, locked remains 1.
  - Also assert rst mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared states, constants and sequence rules for count_seq_monitor
//   IDLE/ACQUIRE/LOCKED state enum, mode encodings, last counter value,
//   is_legal(mode,val) and next_val(mode,val) for both monitored counter modes.
package count_seq_pkg;

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   localparam logic       MODE_A   = 1'b0;
   localparam logic       MODE_B   = 1'b1;
   localparam logic [2:0] LAST_VAL = 3'd6;

   function automatic logic is_legal(input logic mode, input logic [2:0] val);
      return (mode == MODE_A) ? (val != 3'd7)
                              : (val inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
   endfunction

   function automatic logic [2:0] next_val(input logic mode, input logic [2:0] val);
      return (mode == MODE_A) ? ((val == LAST_VAL) ? 3'd0 : val + 3'd1)
                              : (val == 3'd0) ? 3'd1
                              : (val == 3'd1) ? 3'd2
                              : (val == 3'd2) ? 3'd4
                              : (val == 3'd4) ? 3'd6 : 3'd0;
   endfunction

endpackage

// File: rtl/count_seq_next.sv
// count_seq_next: combinational step checker for one counter sample
//   mode     in  0 = binary 0..6, 1 = skip sequence 0,1,2,4,6
//   prev     in  previously accepted counter value
//   count_in in  current counter value
//   legal    out count_in is a value the selected counter can produce
//   match    out count_in is the legal successor of prev
//   is_wrap  out step is the 6->0 rollover
module count_seq_next
   import count_seq_pkg::*;
(
   input  logic       mode,
   input  logic [2:0] prev,
   input  logic [2:0] count_in,
   output logic       legal,
   output logic       match,
   output logic       is_wrap
);

   assign legal   = is_legal(mode, count_in);
   assign match   = count_in == next_val(mode, prev);
   assign is_wrap = (prev == LAST_VAL) && (count_in == 3'd0);

endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks a mod-7 or skip-sequence counter, locks after a run of good steps
//   clk, rst (async, active high)
//   mode        in  0 = mode A (0..6), 1 = mode B (0,1,2,4,6)
//   valid_in    in  count_in is sampled this cycle
//   count_in    in  counter value under test
//   clear       in  synchronous clear of err_count / err_sticky
//   locked      out high while LOCKED
//   wrap_pulse  out one-cycle pulse on a locked 6->0 step
//   err_pulse   out one-cycle pulse on any error
//   err_sticky  out set on first error until clear/rst
//   err_count   out saturating error count
// Optional: define COUNT_SEQ_HOLD_OK_EN to accept a repeated legal value as a hold.
module count_seq_monitor
   import count_seq_pkg::*;
#(
   parameter int ERR_CNT_W   = 8,
   parameter int LOCK_THRESH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mode,
   input  logic                 valid_in,
   input  logic [2:0]           count_in,
   input  logic                 clear,
   output logic                 locked,
   output logic                 wrap_pulse,
   output logic                 err_pulse,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_t     state, state_n;
   logic [2:0] prev, prev_n;
   logic [3:0] good_cnt, good_n, good_inc;
   logic       mode_q;
   logic       wrap_n, err_n;
   logic       legal, match, is_wrap, hold;

   count_seq_next u_next (
      .mode     (mode),
      .prev     (prev),
      .count_in (count_in),
      .legal    (legal),
      .match    (match),
      .is_wrap  (is_wrap)
   );

`ifdef COUNT_SEQ_HOLD_OK_EN
   // a stalled counter repeats its value; only meaningful once a prev exists
   assign hold = (state != IDLE) && (count_in == prev);
`else
   assign hold = 1'b0;
`endif

   assign good_inc = good_cnt + 4'd1;
   assign locked   = state == LOCKED;

   always_comb begin
      state_n = state;
      prev_n  = prev;
      good_n  = good_cnt;
      wrap_n  = 1'b0;
      err_n   = 1'b0;
      if (mode != mode_q) begin
         // mode switch restarts acquisition silently, even over a valid sample
         state_n = IDLE;
         good_n  = '0;
      end else if (valid_in) begin
         if (!legal) begin
            err_n   = 1'b1;
            state_n = IDLE;
            good_n  = '0;
         end else if (!hold) begin
            prev_n = count_in;
            case (state)
               IDLE: begin
                  state_n = ACQUIRE;
                  good_n  = '0;
               end
               ACQUIRE: begin
                  good_n = match ? good_inc : '0;
                  if (match && good_inc == 4'(LOCK_THRESH)) begin
                     state_n = LOCKED;
                     good_n  = '0;
                  end
               end
               LOCKED: begin
                  wrap_n = match & is_wrap;
                  if (!match) begin
                     err_n   = 1'b1;
                     state_n = ACQUIRE;
                     good_n  = '0;
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         prev       <= '0;
         good_cnt   <= '0;
         mode_q     <= MODE_A;
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_n;
         prev       <= prev_n;
         good_cnt   <= good_n;
         mode_q     <= mode;
         wrap_pulse <= wrap_n;
         err_pulse  <= err_n;
         // clear wins over a coincident error; the pulse itself still fires
         err_sticky <= clear ? 1'b0 : (err_sticky | err_n);
         err_count  <= clear ? '0
                     : (err_n && err_count != {ERR_CNT_W{1'b1}}) ? err_count + 1'b1
                     : err_count;
      end
   end

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: table vectors, directed corner sequences and random stimulus vs a sequence model
module tb_count_seq_monitor;

   localparam int ERR_CNT_W   = 8;
   localparam int LOCK_THRESH = 3;
`ifdef COUNT_SEQ_HOLD_OK_EN
   localparam bit HOLD_OK = 1'b1;
`else
   localparam bit HOLD_OK = 1'b0;
`endif

   logic                 clk, rst, mode, valid_in, clear;
   logic [2:0]           count_in;
   logic                 locked, wrap_pulse, err_pulse, err_sticky;
   logic [ERR_CNT_W-1:0] err_count;

   count_seq_monitor #(.ERR_CNT_W(ERR_CNT_W), .LOCK_THRESH(LOCK_THRESH)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .valid_in   (valid_in),
      .count_in   (count_in),
      .clear      (clear),
      .locked     (locked),
      .wrap_pulse (wrap_pulse),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: each mode is a cyclic list of values; legality is
   // membership, the expected successor is the next list entry.
   int m_state, m_prev, m_good, m_cnt;
   bit m_modeq, m_sticky, m_lock, m_wrap, m_err;

   function automatic int seq_idx(input bit md, input int v);
      int sb[5] = '{0, 1, 2, 4, 6};
      if (!md) return (v >= 0 && v <= 6) ? v : -1;
      for (int i = 0; i < 5; i++) if (sb[i] == v) return i;
      return -1;
   endfunction

   function automatic int seq_next(input bit md, input int v);
      int sb[5] = '{0, 1, 2, 4, 6};
      int i = seq_idx(md, v);
      if (i < 0) return 0;
      return md ? sb[(i + 1) % 5] : (i + 1) % 7;
   endfunction

   task automatic m_reset();
      m_state = 0; m_prev = 0; m_good = 0; m_cnt = 0;
      m_modeq = 0; m_sticky = 0; m_lock = 0; m_wrap = 0; m_err = 0;
   endtask

   task automatic m_step(input bit md, input bit v, input int c, input bit clr);
      bit mt;
      m_wrap = 0;
      m_err  = 0;
      if (md != m_modeq) begin
         m_state = 0;
         m_good  = 0;
      end else if (v) begin
         if (seq_idx(md, c) < 0) begin
            m_err = 1; m_state = 0; m_good = 0;
         end else if (HOLD_OK && m_state != 0 && c == m_prev) begin
         end else begin
            mt = (c == seq_next(md, m_prev));
            if (m_state == 0) begin
               m_state = 1; m_good = 0;
            end else if (m_state == 1) begin
               m_good = mt ? m_good + 1 : 0;
               if (m_good == LOCK_THRESH) begin m_state = 2; m_good = 0; end
            end else if (mt) begin
               m_wrap = (m_prev == 6 && c == 0);
            end else begin
               m_err = 1; m_state = 1;
            end
            m_prev = c;
         end
      end
      m_modeq = md;
      if (clr) begin
         m_cnt = 0; m_sticky = 0;
      end else if (m_err) begin
         m_cnt = (m_cnt < (1 << ERR_CNT_W) - 1) ? m_cnt + 1 : m_cnt;
         m_sticky = 1;
      end
      m_lock = (m_state == 2);
   endtask

   task automatic cyc(input bit md, input bit v, input int c, input bit clr);
      mode = md; valid_in = v; count_in = 3'(c); clear = clr;
      @(posedge clk);
      m_step(md, v, c, clr);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_locked"}, int'(locked), int'(m_lock));
      chk({tag, "_wrap"}, int'(wrap_pulse), int'(m_wrap));
      chk({tag, "_err"}, int'(err_pulse), int'(m_err));
      chk({tag, "_sticky"}, int'(err_sticky), int'(m_sticky));
      chk({tag, "_count"}, int'(err_count), m_cnt);
   endtask

   task automatic run(input bit md, input int c, input string tag);
      cyc(md, 1, c, 0);
      chk_model(tag);
   endtask

   typedef struct packed {
      logic       md, v;
      logic [2:0] c;
      logic       clr, l, w, e, s;
      logic [7:0] n;
   } vec_t;

   vec_t tbl[16];
   int   wraps;
   bit   gm;
   int   gv, c, r;
   bit   v, clr;

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[3]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[4]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[5]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[6]  = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[7]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      tbl[8]  = '{1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[9]  = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
      tbl[10] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
      tbl[11] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
      tbl[12] = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
      tbl[13] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
      tbl[14] = '{1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2};
      tbl[15] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

      rst = 1'b1; mode = 1'b0; valid_in = 1'b0; count_in = 3'd0; clear = 1'b0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", int'(locked), 0);
      chk("rst_wrap", int'(wrap_pulse), 0);
      chk("rst_err", int'(err_pulse), 0);
      chk("rst_sticky", int'(err_sticky), 0);
      chk("rst_count", int'(err_count), 0);
      rst = 1'b0;

      // mode A lock, wrap, relock after a counter reset, illegal 7, clear
      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].md, tbl[i].v, int'(tbl[i].c), tbl[i].clr);
         chk($sformatf("vec%0d_locked", i), int'(locked), int'(tbl[i].l));
         chk($sformatf("vec%0d_wrap", i), int'(wrap_pulse), int'(tbl[i].w));
         chk($sformatf("vec%0d_err", i), int'(err_pulse), int'(tbl[i].e));
         chk($sformatf("vec%0d_sticky", i), int'(err_sticky), int'(tbl[i].s));
         chk($sformatf("vec%0d_count", i), int'(err_count), int'(tbl[i].n));
      end

      // mode B: switch cycle is silent, then 0,1,2,4 locks, 6->0 wraps once, 5 errors
      cyc(1, 0, 0, 0);
      chk_model("b_switch");
      chk("b_switch_err", int'(err_pulse), 0);
      wraps = 0;
      foreach (tbl[i]) if (i < 7) begin
         run(1, seq_next(1, (i == 0) ? 6 : seq_next(1, 6) + 0) * 0 + (i == 0 ? 0 : i == 1 ? 1 : i == 2 ? 2 : i == 3 ? 4 : i == 4 ? 6 : i == 5 ? 0 : 1), "b_seq");
         wraps += int'(wrap_pulse);
         if (i == 2) chk("b_not_yet_locked", int'(locked), 0);
         if (i == 3) chk("b_locked_after_4", int'(locked), 1);
      end
      chk("b_wrap_once", wraps, 1);
      run(1, 5, "b_illegal");
      chk("b_illegal_err", int'(err_pulse), 1);
      chk("b_illegal_count", int'(err_count), 1);
      chk("b_illegal_unlock", int'(locked), 0);

      // locked in A, then mode toggle drops lock without an error
      cyc(0, 0, 0, 0);
      chk_model("a_switch");
      run(0, 0, "a_lk"); run(0, 1, "a_lk"); run(0, 2, "a_lk"); run(0, 3, "a_lk");
      chk("a_locked", int'(locked), 1);
      run(1, 4, "toggle");
      chk("toggle_unlock", int'(locked), 0);
      chk("toggle_no_err", int'(err_pulse), 0);
      run(1, 0, "b_re"); run(1, 1, "b_re"); run(1, 2, "b_re"); run(1, 4, "b_re");
      chk("b_relocked", int'(locked), 1);

      // repeated 4 while locked
      run(1, 4, "hold");
      chk("hold_err", int'(err_pulse), HOLD_OK ? 0 : 1);
      chk("hold_locked", int'(locked), HOLD_OK ? 1 : 0);

      // async reset mid-sequence clears every output before the next edge
      run(1, 6, "pre_rst");
      #2 rst = 1'b1;
      #1;
      chk("arst_locked", int'(locked), 0);
      chk("arst_wrap", int'(wrap_pulse), 0);
      chk("arst_err", int'(err_pulse), 0);
      chk("arst_sticky", int'(err_sticky), 0);
      chk("arst_count", int'(err_count), 0);
      m_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // saturation: 260 illegal 7s, then clear alongside one more 7
      cyc(0, 0, 0, 1);
      chk_model("sat_pre");
      for (int i = 0; i < 260; i++) run(0, 7, "sat");
      chk("sat_count", int'(err_count), 255);
      chk("sat_err_still", int'(err_pulse), 1);
      cyc(0, 1, 7, 1);
      chk_model("sat_clr");
      chk("clr_count", int'(err_count), 0);
      chk("clr_sticky", int'(err_sticky), 0);
      chk("clr_err", int'(err_pulse), 1);

      // random: mostly well-behaved counter with stalls, glitches, mode flips, clears
      gm = 0; gv = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) gm = ~gm;
         v = $urandom_range(0, 9) < 8;
         r = $urandom_range(0, 99);
         c = (r < 80) ? seq_next(gm, gv) : (r < 88) ? gv : int'($urandom_range(0, 7));
         clr = $urandom_range(0, 99) == 0;
         cyc(gm, v, c, clr);
         chk_model("rnd");
         if (v && seq_idx(gm, c) >= 0) gv = c;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
